airlock_pressure_seq: RTL

Parametrised airlock pressure sequencer that runs both fill-and-pressurize and drain-and-depressurize cycles for the chamber between the inner and outer doors.
- Drives the fill and drain pumps.
- Debounces the pressure sensor over a settle window.
- Enforces door interlocks and a per-operation timeout.
- Latches a sticky fault code.
Sits under the airlock top-level controller, which issues start requests and reads done/fault status.

---
 rtl/airlock_pressure_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/airlock_pressure_seq.sv
// Airlock pressure sequencer: runs fill/pressurize and drain/depressurize cycles,
// debounces the pressure sensor, enforces door interlocks and a per-operation timeout.
module airlock_pressure_seq #(
  parameter int CNT_W         = 8,
  parameter int FILL_TIMEOUT  = 200,
  parameter int DRAIN_TIMEOUT = 200,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start_fill,
  input  logic             start_drain,
  input  logic             InnerClosed,
  input  logic             OuterClosed,
  input  logic             Pressurized,
  input  logic             clear_fault,
  output logic             pump_fill,
  output logic             pump_drain,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] progress
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, FAULT} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] elapsed_reg;
  logic [SET_W-1:0] settle_reg;
  logic             done_reg;
  logic [1:0]       fault_code_reg;

  logic doors_ok;
  logic target_met;
  logic settled;
  logic timeout_hit;

  assign doors_ok   = InnerClosed && OuterClosed;
  // FILL waits for pressure to rise, DRAIN for it to fall.
  assign target_met = (state_reg == FILL) ? Pressurized : !Pressurized;
  assign settled    = target_met && (settle_reg == SET_W'(SETTLE_CYCLES - 1));
  assign timeout_hit = (state_reg == FILL) ? (elapsed_reg == CNT_W'(FILL_TIMEOUT - 1))
                                           : (elapsed_reg == CNT_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= IDLE;
      elapsed_reg    <= '0;
      settle_reg     <= '0;
      done_reg       <= 1'b0;
      fault_code_reg <= 2'b00;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_fill && !start_drain && doors_ok && !Pressurized) begin
            state_reg   <= FILL;
            elapsed_reg <= '0;
            settle_reg  <= '0;
          end else if (start_drain && !start_fill && doors_ok && Pressurized) begin
            state_reg   <= DRAIN;
            elapsed_reg <= '0;
            settle_reg  <= '0;
          end
        end
        FILL, DRAIN: begin
          if (!doors_ok) begin
            state_reg      <= FAULT;
            fault_code_reg <= 2'b01;
          end else if (settled) begin
            // Completion beats a coincident timeout.
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end else if (timeout_hit) begin
            state_reg      <= FAULT;
            fault_code_reg <= 2'b10;
          end else begin
            if (elapsed_reg != '1) begin
              elapsed_reg <= elapsed_reg + 1'b1;
            end
            settle_reg <= target_met ? settle_reg + 1'b1 : '0;
          end
        end
        FAULT: begin
          if (clear_fault && doors_ok) begin
            state_reg      <= IDLE;
            fault_code_reg <= 2'b00;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pump_fill  = (state_reg == FILL);
  assign pump_drain = (state_reg == DRAIN);
  assign busy       = (state_reg == FILL) || (state_reg == DRAIN);
  assign fault      = (state_reg == FAULT);
  assign done       = done_reg;
  assign fault_code = fault_code_reg;
  assign progress   = elapsed_reg;

endmodule
